// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared codes, state encoding and defaults for the load/store unit
package lsu_pkg;

    localparam int MEM_WORDS = 1024;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] MEM_IDLE = 2'b00;
    localparam logic [1:0] MEM_WORD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STORE,
        ST_RMW_RD,
        ST_RMW_WR
    } lsu_state_e;

    // Stores only have the signed-looking codes; the unsigned ones are load-only.
    function automatic logic funct3_legal(input logic is_load, input logic [2:0] f3);
        logic ok;
        ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (is_load) begin
            ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
        end
        return ok;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - load lane extraction and sub-word store merging
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    input  logic [31:0] rdata,
    input  logic [15:0] store_half,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = rdata[{byte_off, 3'b000} +: 8];
        half_lane = byte_off[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_B:    load_data = {{24{byte_lane[7]}}, byte_lane};
            F3_BU:   load_data = {24'h0, byte_lane};
            F3_H:    load_data = {{16{half_lane[15]}}, half_lane};
            F3_HU:   load_data = {16'h0, half_lane};
            default: load_data = rdata;
        endcase

        merged_word = rdata;
        if (funct3 == F3_B) begin
            merged_word[{byte_off, 3'b000} +: 8] = store_half[7:0];
        end else if (funct3 == F3_H) begin
            merged_word = byte_off[1] ? {store_half, rdata[15:0]} : {rdata[31:16], store_half};
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - MEM-stage load/store unit with read-modify-write for SB/SH
module load_store_unit #(
    parameter int MEM_WORDS = lsu_pkg::MEM_WORDS
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        MEM_READ,
    input  logic        MEM_WRITE,
    input  logic [2:0]  FUNCT3,
    input  logic [31:0] ADDR,
    input  logic [31:0] STORE_DATA,
    output logic [31:0] LOAD_DATA,
    output logic        RESP_VALID,
    output logic        FAULT,
    output logic [1:0]  DM_READ,
    output logic [1:0]  DM_WRITE,
    output logic [31:0] DM_ADDR,
    output logic [31:0] DM_WDATA,
    input  logic [31:0] DM_RDATA
);
    import lsu_pkg::*;

    localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) * 33'd4;

    lsu_state_e  state_q, state_d;
    logic [1:0]  byte_off_q, byte_off_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [15:0] sdata_q, sdata_d;
    logic [31:0] load_data_q, load_data_d;
    logic        resp_valid_q, resp_valid_d;
    logic        fault_q, fault_d;
    logic [1:0]  dm_read_q, dm_read_d;
    logic [1:0]  dm_write_q, dm_write_d;
    logic [31:0] dm_addr_q, dm_addr_d;
    logic [31:0] dm_wdata_q, dm_wdata_d;

    logic [31:0] align_load;
    logic [31:0] align_merge;
    logic        is_half;
    logic        req_fault;

    lsu_align u_align (
        .funct3      (funct3_q),
        .byte_off    (byte_off_q),
        .rdata       (DM_RDATA),
        .store_half  (sdata_q),
        .load_data   (align_load),
        .merged_word (align_merge)
    );

    always_comb begin
        is_half   = (FUNCT3 == F3_H) || (FUNCT3 == F3_HU);
        req_fault = (MEM_READ && MEM_WRITE)
                 || !funct3_legal(MEM_READ, FUNCT3)
                 || (is_half && ADDR[0])
                 || ((FUNCT3 == F3_W) && (ADDR[1:0] != 2'b00))
                 || ({1'b0, ADDR} >= ADDR_LIMIT);
    end

    // Strobes and the response pulse default low; each state re-asserts what it needs next cycle.
    always_comb begin
        state_d      = state_q;
        byte_off_d   = byte_off_q;
        funct3_d     = funct3_q;
        sdata_d      = sdata_q;
        load_data_d  = load_data_q;
        resp_valid_d = 1'b0;
        fault_d      = 1'b0;
        dm_read_d    = MEM_IDLE;
        dm_write_d   = MEM_IDLE;
        dm_addr_d    = dm_addr_q;
        dm_wdata_d   = dm_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (REQ_VALID && (MEM_READ || MEM_WRITE)) begin
                    if (req_fault) begin
                        resp_valid_d = 1'b1;
                        fault_d      = 1'b1;
                        load_data_d  = 32'h0;
                    end else begin
                        byte_off_d = ADDR[1:0];
                        funct3_d   = FUNCT3;
                        sdata_d    = STORE_DATA[15:0];
                        dm_addr_d  = {ADDR[31:2], 2'b00};
                        if (MEM_READ) begin
                            state_d   = ST_LOAD;
                            dm_read_d = MEM_WORD;
                        end else if (FUNCT3 == F3_W) begin
                            state_d    = ST_STORE;
                            dm_write_d = MEM_WORD;
                            dm_wdata_d = STORE_DATA;
                        end else begin
                            state_d   = ST_RMW_RD;
                            dm_read_d = MEM_WORD;
                        end
                    end
                end
            end
            ST_LOAD: begin
                load_data_d  = align_load;
                resp_valid_d = 1'b1;
                state_d      = ST_IDLE;
            end
            ST_STORE: begin
                resp_valid_d = 1'b1;
                state_d      = ST_IDLE;
            end
            ST_RMW_RD: begin
                dm_wdata_d = align_merge;
                dm_write_d = MEM_WORD;
                state_d    = ST_RMW_WR;
            end
            ST_RMW_WR: begin
                resp_valid_d = 1'b1;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= ST_IDLE;
            byte_off_q   <= 2'b00;
            funct3_q     <= 3'b000;
            sdata_q      <= 16'h0;
            load_data_q  <= 32'h0;
            resp_valid_q <= 1'b0;
            fault_q      <= 1'b0;
            dm_read_q    <= MEM_IDLE;
            dm_write_q   <= MEM_IDLE;
            dm_addr_q    <= 32'h0;
            dm_wdata_q   <= 32'h0;
        end else begin
            state_q      <= state_d;
            byte_off_q   <= byte_off_d;
            funct3_q     <= funct3_d;
            sdata_q      <= sdata_d;
            load_data_q  <= load_data_d;
            resp_valid_q <= resp_valid_d;
            fault_q      <= fault_d;
            dm_read_q    <= dm_read_d;
            dm_write_q   <= dm_write_d;
            dm_addr_q    <= dm_addr_d;
            dm_wdata_q   <= dm_wdata_d;
        end
    end

    assign REQ_READY  = (state_q == ST_IDLE);
    assign LOAD_DATA  = load_data_q;
    assign RESP_VALID = resp_valid_q;
    assign FAULT      = fault_q;
    assign DM_READ    = dm_read_q;
    assign DM_WRITE   = dm_write_q;
    assign DM_ADDR    = dm_addr_q;
    assign DM_WDATA   = dm_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit
module tb_load_store_unit;

    logic        CLK;
    logic        RESET;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [2:0]  FUNCT3;
    logic [31:0] ADDR;
    logic [31:0] STORE_DATA;
    logic [31:0] LOAD_DATA;
    logic        RESP_VALID;
    logic        FAULT;
    logic [1:0]  DM_READ;
    logic [1:0]  DM_WRITE;
    logic [31:0] DM_ADDR;
    logic [31:0] DM_WDATA;
    logic [31:0] DM_RDATA;

    logic [31:0] mem [0:1023];
    int rd_cnt;
    int wr_cnt;
    int both_cnt;
    int checks;
    int failures;

    load_store_unit #(.MEM_WORDS(1024)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .REQ_VALID  (REQ_VALID),
        .REQ_READY  (REQ_READY),
        .MEM_READ   (MEM_READ),
        .MEM_WRITE  (MEM_WRITE),
        .FUNCT3     (FUNCT3),
        .ADDR       (ADDR),
        .STORE_DATA (STORE_DATA),
        .LOAD_DATA  (LOAD_DATA),
        .RESP_VALID (RESP_VALID),
        .FAULT      (FAULT),
        .DM_READ    (DM_READ),
        .DM_WRITE   (DM_WRITE),
        .DM_ADDR    (DM_ADDR),
        .DM_WDATA   (DM_WDATA),
        .DM_RDATA   (DM_RDATA)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign DM_RDATA = mem[DM_ADDR[11:2]];

    always @(posedge CLK) begin
        if (DM_WRITE == 2'b11) mem[DM_ADDR[11:2]] <= DM_WDATA;
        if (DM_READ == 2'b11) rd_cnt <= rd_cnt + 1;
        if (DM_WRITE == 2'b11) wr_cnt <= wr_cnt + 1;
        if (DM_READ != 2'b00 && DM_WRITE != 2'b00) both_cnt <= both_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] data;
        int          lat;
        logic        flt;
        logic        chk_ld;
        logic [31:0] ld;
        int          rds;
        int          wrs;
        logic        chk_mem;
        int          midx;
        logic [31:0] mval;
    } vec_t;

    vec_t vecs [19];

    task automatic do_req(input vec_t v, input int idx);
        int r0, w0, lat;
        logic flt;
        logic [31:0] ld;
        @(negedge CLK);
        check($sformatf("v%0d_ready", idx), {31'h0, REQ_READY}, 32'h1);
        r0 = rd_cnt;
        w0 = wr_cnt;
        REQ_VALID = 1'b1; MEM_READ = v.rd; MEM_WRITE = v.wr;
        FUNCT3 = v.f3; ADDR = v.addr; STORE_DATA = v.data;
        @(posedge CLK);
        #1 REQ_VALID = 1'b0; MEM_READ = 1'b0; MEM_WRITE = 1'b0;
        lat = -1; flt = 1'b0; ld = 32'h0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge CLK);
            if (RESP_VALID) begin
                lat = k; flt = FAULT; ld = LOAD_DATA;
                break;
            end
        end
        check($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.lat));
        check($sformatf("v%0d_fault", idx), {31'h0, flt}, {31'h0, v.flt});
        if (v.chk_ld) check($sformatf("v%0d_load_data", idx), ld, v.ld);
        check($sformatf("v%0d_reads", idx), 32'(rd_cnt - r0), 32'(v.rds));
        check($sformatf("v%0d_writes", idx), 32'(wr_cnt - w0), 32'(v.wrs));
        @(negedge CLK);
        check($sformatf("v%0d_pulse_end", idx), {31'h0, RESP_VALID}, 32'h0);
        if (v.chk_mem) check($sformatf("v%0d_mem", idx), mem[v.midx], v.mval);
    endtask

    initial begin
        int seen, w0, r0;
        checks = 0; failures = 0;
        rd_cnt = 0; wr_cnt = 0; both_cnt = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[1]    = 32'h00000056;
        mem[1023] = 32'h0BADF00D;

        //          rd wr f3      addr          data          lat flt chk ld            rd wr cm idx mval
        vecs[0]  = '{1, 0, 3'b010, 32'h4,      32'h0,        2, 0, 1, 32'h00000056, 1, 0, 0, 0, 32'h0};
        vecs[1]  = '{0, 1, 3'b010, 32'h8,      32'hDEADBEEF, 2, 0, 0, 32'h0,        0, 1, 1, 2, 32'hDEADBEEF};
        vecs[2]  = '{1, 0, 3'b000, 32'hB,      32'h0,        2, 0, 1, 32'hFFFFFFDE, 1, 0, 0, 0, 32'h0};
        vecs[3]  = '{1, 0, 3'b100, 32'hB,      32'h0,        2, 0, 1, 32'h000000DE, 1, 0, 0, 0, 32'h0};
        vecs[4]  = '{1, 0, 3'b101, 32'hA,      32'h0,        2, 0, 1, 32'h0000DEAD, 1, 0, 0, 0, 32'h0};
        vecs[5]  = '{0, 1, 3'b001, 32'hA,      32'h00001234, 3, 0, 0, 32'h0,        1, 1, 1, 2, 32'h1234BEEF};
        vecs[6]  = '{1, 0, 3'b010, 32'h8,      32'h0,        2, 0, 1, 32'h1234BEEF, 1, 0, 0, 0, 32'h0};
        vecs[7]  = '{1, 0, 3'b001, 32'h8,      32'h0,        2, 0, 1, 32'hFFFFBEEF, 1, 0, 0, 0, 32'h0};
        vecs[8]  = '{1, 0, 3'b000, 32'h9,      32'h0,        2, 0, 1, 32'hFFFFFFBE, 1, 0, 0, 0, 32'h0};
        vecs[9]  = '{0, 1, 3'b000, 32'h9,      32'h000000AA, 3, 0, 0, 32'h0,        1, 1, 1, 2, 32'h1234AAEF};
        vecs[10] = '{1, 0, 3'b101, 32'h8,      32'h0,        2, 0, 1, 32'h0000AAEF, 1, 0, 0, 0, 32'h0};
        vecs[11] = '{1, 0, 3'b010, 32'h6,      32'h0,        1, 1, 1, 32'h0,        0, 0, 0, 0, 32'h0};
        vecs[12] = '{0, 1, 3'b001, 32'h5,      32'h0,        1, 1, 1, 32'h0,        0, 0, 0, 0, 32'h0};
        vecs[13] = '{0, 1, 3'b010, 32'h1000,   32'h0,        1, 1, 1, 32'h0,        0, 0, 0, 0, 32'h0};
        vecs[14] = '{1, 1, 3'b010, 32'h0,      32'h0,        1, 1, 1, 32'h0,        0, 0, 0, 0, 32'h0};
        vecs[15] = '{1, 0, 3'b011, 32'h0,      32'h0,        1, 1, 1, 32'h0,        0, 0, 0, 0, 32'h0};
        vecs[16] = '{0, 1, 3'b100, 32'h0,      32'h0,        1, 1, 1, 32'h0,        0, 0, 0, 0, 32'h0};
        vecs[17] = '{1, 0, 3'b010, 32'hFFC,    32'h0,        2, 0, 1, 32'h0BADF00D, 1, 0, 0, 0, 32'h0};
        vecs[18] = '{1, 0, 3'b101, 32'hFFE,    32'h0,        2, 0, 1, 32'h00000BAD, 1, 0, 0, 0, 32'h0};

        RESET = 1'b1; REQ_VALID = 1'b0; MEM_READ = 1'b0; MEM_WRITE = 1'b0;
        FUNCT3 = 3'b000; ADDR = 32'h0; STORE_DATA = 32'h0;
        #12;
        check("rst_ready", {31'h0, REQ_READY}, 32'h1);
        check("rst_resp", {31'h0, RESP_VALID}, 32'h0);
        check("rst_fault", {31'h0, FAULT}, 32'h0);
        check("rst_load_data", LOAD_DATA, 32'h0);
        check("rst_strobes", {28'h0, DM_READ, DM_WRITE}, 32'h0);
        check("rst_dm_addr", DM_ADDR, 32'h0);
        check("rst_dm_wdata", DM_WDATA, 32'h0);
        @(negedge CLK);
        RESET = 1'b0;

        for (int i = 0; i < 19; i++) do_req(vecs[i], i);

        // Request with neither read nor write must be ignored.
        @(negedge CLK);
        r0 = rd_cnt; w0 = wr_cnt; seen = 0;
        REQ_VALID = 1'b1; MEM_READ = 1'b0; MEM_WRITE = 1'b0; FUNCT3 = 3'b010; ADDR = 32'h4;
        repeat (3) begin
            @(negedge CLK);
            if (RESP_VALID || !REQ_READY) seen++;
        end
        REQ_VALID = 1'b0;
        check("ignored_no_resp", 32'(seen), 32'h0);
        check("ignored_no_access", 32'(rd_cnt - r0 + wr_cnt - w0), 32'h0);

        // Reset during RMW_RD of SB 0x8 aborts with no write or response.
        @(negedge CLK);
        REQ_VALID = 1'b1; MEM_WRITE = 1'b1; FUNCT3 = 3'b000; ADDR = 32'h8; STORE_DATA = 32'h55;
        @(posedge CLK);
        #1 REQ_VALID = 1'b0; MEM_WRITE = 1'b0;
        @(negedge CLK);
        check("abort_in_rmw_rd", {30'h0, DM_READ}, 32'h3);
        w0 = wr_cnt;
        RESET = 1'b1;
        #1;
        check("abort_strobes_drop", {28'h0, DM_READ, DM_WRITE}, 32'h0);
        check("abort_ready", {31'h0, REQ_READY}, 32'h1);
        @(negedge CLK);
        RESET = 1'b0;
        seen = 0;
        repeat (4) begin
            @(negedge CLK);
            if (RESP_VALID) seen++;
        end
        check("abort_no_resp", 32'(seen), 32'h0);
        check("abort_no_write", 32'(wr_cnt - w0), 32'h0);
        check("abort_mem_word2", mem[2], 32'h1234AAEF);

        // LW 0x4 then SW 0x0 held on the request lines: second accepted in first's response cycle.
        @(negedge CLK);
        REQ_VALID = 1'b1; MEM_READ = 1'b1; FUNCT3 = 3'b010; ADDR = 32'h4;
        @(posedge CLK);
        #1 MEM_READ = 1'b0; MEM_WRITE = 1'b1; ADDR = 32'h0; STORE_DATA = 32'hCAFEF00D;
        @(negedge CLK);
        check("b2b_stall", {30'h0, REQ_READY, RESP_VALID}, 32'h0);
        @(negedge CLK);
        check("b2b_resp1", {30'h0, REQ_READY, RESP_VALID}, 32'h3);
        check("b2b_resp1_data", LOAD_DATA, 32'h00000056);
        @(posedge CLK);
        #1 REQ_VALID = 1'b0; MEM_WRITE = 1'b0;
        @(negedge CLK);
        check("b2b_store_strobe", {28'h0, DM_READ, DM_WRITE, 1'b0, RESP_VALID}, 32'h0000000C);
        @(negedge CLK);
        check("b2b_resp2", {30'h0, FAULT, RESP_VALID}, 32'h1);
        @(negedge CLK);
        check("b2b_mem_word0", mem[0], 32'hCAFEF00D);

        check("never_both_strobes", 32'(both_cnt), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, the number of words of the attached data memory.
REQ-002 SHALL have port CLK  in  1  system clock; all state is updated on the rising edge.
REQ-003 SHALL have port RESET  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port REQ_VALID  in  1  MEM-stage request present.
REQ-005 SHALL have port REQ_READY  out  1  unit can accept a request; high only in IDLE.
REQ-006 SHALL have port MEM_READ  in  1  request is a load.
REQ-007 SHALL have port MEM_WRITE  in  1  request is a store.
REQ-008 SHALL have port FUNCT3  in  3  RV32 width code: LB 000, LH 001, LW 010, LBU 100, LHU 101, SB 000, SH 001, SW 010.
REQ-009 SHALL have port ADDR  in  32  byte address.
REQ-010 SHALL have port STORE_DATA  in  32  store operand.
REQ-011 SHALL have port LOAD_DATA  out  32  extended load result; held until the next response.
REQ-012 SHALL have port RESP_VALID  out  1  one-cycle completion pulse.
REQ-013 SHALL have port FAULT  out  1  qualifies RESP_VALID: misaligned, out-of-range or illegal access.
REQ-014 SHALL have ports DM_READ and DM_WRITE  out  2 each  data-memory strobes: 2'b11 word access, 2'b00 idle.
REQ-015 SHALL have ports DM_ADDR  out  32  word-aligned address; DM_WDATA  out  32  write word; DM_RDATA  in  32  combinational read word.

Function
REQ-016 SHALL accept a request on a rising edge with REQ_VALID=1, REQ_READY=1 and exactly one of MEM_READ or MEM_WRITE set, registering ADDR, FUNCT3 and STORE_DATA.
REQ-017 SHALL ignore a request with neither MEM_READ nor MEM_WRITE set: no state change and no response.
REQ-018 SHALL not enter any access state for a FAULT request, defined as:
- both MEM_READ and MEM_WRITE set;
- undefined FUNCT3;
- halfword with ADDR[0]=1;
- word with ADDR[1:0]!=0;
- ADDR >= MEM_WORDS*4.
On such a request it SHALL stay IDLE, pulse RESP_VALID=1 with FAULT=1 in the next cycle, and set LOAD_DATA=0.
REQ-019 SHALL use states IDLE, LOAD, STORE, RMW_RD and RMW_WR.
REQ-020 SHALL make these state transitions:
- IDLE to LOAD on a good load, to STORE on a good SW, to RMW_RD on a good SB or SH;
- RMW_RD to RMW_WR;
- LOAD, STORE and RMW_WR to IDLE.
REQ-021 SHALL, in LOAD, drive DM_READ=11 and DM_ADDR={addr[31:2],2'b00}, and at the closing edge register the extracted lane into LOAD_DATA and assert RESP_VALID for the following cycle.
REQ-022 SHALL extract load lanes as follows:
- LB/LBU: byte addr[1:0], sign- or zero-extended;
- LH/LHU: halfword addr[1], sign- or zero-extended;
- LW: whole word.
REQ-023 SHALL, in STORE, drive DM_WRITE=11 and DM_WDATA=STORE_DATA; the write commits at the closing edge and RESP_VALID follows in the next cycle.
REQ-024 SHALL, in RMW_RD, drive DM_READ=11 and register the read word with lane addr[1:0] (SB, STORE_DATA[7:0]) or lane addr[1] (SH, STORE_DATA[15:0]) replaced; in RMW_WR it SHALL drive DM_WRITE=11 with the merged word, and RESP_VALID follows.
REQ-025 SHALL drive DM_READ and DM_WRITE to 00 in every state other than the one named for each, and SHALL never assert both at once.
REQ-026 SHALL keep RESP_VALID high for exactly one cycle per accepted request, with FAULT=0 except as in REQ-018.
REQ-027 SHALL, in the RESP_VALID cycle, be IDLE with REQ_READY=1, so back-to-back requests incur no bubble.
REQ-028 SHALL keep REQ_READY=0 in all non-IDLE states; the pipeline stalls on REQ_VALID && !REQ_READY.
REQ-029 SHALL give latency from acceptance edge to RESP_VALID of 1 cycle for a fault, 2 cycles for LW/LB/LH/SW, and 3 cycles for SB/SH.

Reset
REQ-030 SHALL, while RESET=1, asynchronously force the following:
- state IDLE;
- REQ_READY=1;
- RESP_VALID=0, FAULT=0, LOAD_DATA=0;
- DM_READ=DM_WRITE=00, DM_ADDR=0, DM_WDATA=0.
REQ-031 SHALL, on RESET asserted mid-operation, abort the operation without completing it: no memory write and no response.

Structure
REQ-032 SHALL place the FUNCT3 codes, the state encoding, the DM strobe codes (MEM_IDLE=2'b00, MEM_WORD=2'b11) and MEM_WORDS in the shared package lsu_pkg.
REQ-033 SHALL implement lane extraction and store merging in one combinational sub-module, lsu_align.

Verification
REQ-034 SHALL verify that an LW at 0x4, with memory word 1 = 0x00000056, gives RESP_VALID 2 cycles after acceptance, LOAD_DATA=0x00000056 and FAULT=0.
REQ-035 SHALL verify that SW 0x8 with data 0xDEADBEEF, then LB 0xB, gives 0xFFFFFFDE; LBU 0xB gives 0x000000DE; LHU 0xA gives 0x0000DEAD.
REQ-036 SHALL verify that SH 0xA with data 0x00001234 after REQ-035 writes word 2 = 0x1234BEEF, takes 3 cycles, and issues exactly one read and then one write.
REQ-037 SHALL verify that each of the following gives FAULT=1 and RESP_VALID the next cycle with no DM strobe ever asserted:
- LW 0x6;
- SH 0x5;
- SW 0x1000 with MEM_WORDS=1024;
- MEM_READ=MEM_WRITE=1.
REQ-038 SHALL verify that RESET asserted during RMW_RD of SB 0x8 leaves word 2 unchanged, produces no RESP_VALID, and drops the strobes immediately.
REQ-039 SHALL verify that LW 0x4 followed by SW 0x0 on consecutive ready cycles is accepted back-to-back with no idle cycle between responses.
